// File: rtl/ipv6_udp_chkverify.sv
// IPv6/UDP receive checksum verifier on a 64-bit XGMII stream.
// Sums the pseudo-header addresses, the UDP header and the payload word by word.
// At the end of the frame it folds the sum and reports ok / zero-field / truncated,
// together with the checksum recomputed without the received field.
module ipv6_udp_chkverify (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic        rx_clk_en_i,
  input  logic        ipv6_udp_chk_en_i,
  input  logic        ipv6_flag_i,
  input  logic [10:0] ipv6_addr_base_i,
  input  logic [10:0] eth_count_base_i,
  input  logic [63:0] rxd_i,
  input  logic [7:0]  rxc_i,
  output logic        chk_valid_o,
  output logic        chk_ok_o,
  output logic        chk_zero_o,
  output logic        chk_trunc_o,
  output logic [15:0] chksum_calc_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, FOLD, DONE} state_t;

  state_t state, state_nx;

  // word decode
  logic        start_word, term_word, err_word;
  logic [7:0]  lane_data;
  logic [7:0]  lane_byte_d;
  logic [16:0] b17;

  // length decode
  logic [16:0] lane_off_l;
  logic        l_hi_here, l_lo_here;
  logic [7:0]  l_hi_val, l_lo_val;
  logic        l_known;
  logic [15:0] l_eff;
  logic [16:0] win_end;

  // per-word sums
  logic [16:0] lane_off_s, rel_s;
  logic [7:0]  lane_byte_s;
  logic        lane_acc;
  logic [15:0] lane_word;
  logic [19:0] word_sum_all, word_sum_x;
  logic        any_acc;
  logic [16:0] last_end;
  logic        cs_hi_here, cs_lo_here;
  logic [7:0]  cs_hi_val, cs_lo_val;

  // frame state
  logic [19:0] acc_all_q, acc_x_q;
  logic [15:0] l_q;
  logic        l_have_q;
  logic [7:0]  l_hi_q;
  logic        l_hi_have_q;
  logic [16:0] end_q;
  logic [15:0] cs_q;
  logic        cs_have_q;
  logic        flag_q;

  // fold / results
  logic [19:0] t_all, t_x;
  logic [16:0] f1_all, f1_x;
  logic [15:0] f2_all, f2_x;
  logic        fold_trunc, fold_zero;
  logic        res_ok_q, res_zero_q, res_trunc_q;
  logic [15:0] res_calc_q;

  // Adding the upper nibble back in each cycle is an end-around carry, so the
  // 20-bit accumulator never overflows however long the datagram is.
  function automatic logic [19:0] acc_add(input logic [19:0] acc, input logic [19:0] word);
    return 20'(acc[15:0]) + 20'(acc[19:16]) + word;
  endfunction

  // Classify the word: start, terminate, error, and which lanes carry data before the terminate.
  always_comb begin
    b17         = 17'(ipv6_addr_base_i);
    start_word  = rxc_i[0] && (rxd_i[7:0] == 8'hFB);
    term_word   = 1'b0;
    err_word    = 1'b0;
    lane_data   = '0;
    lane_byte_d = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      lane_byte_d  = rxd_i[8*n +: 8];
      lane_data[n] = !rxc_i[n] && !term_word;
      if (rxc_i[n] && lane_byte_d == 8'hFD) term_word = 1'b1;
      if (rxc_i[n] && lane_byte_d == 8'hFE) err_word  = 1'b1;
    end
  end

  // Locate the UDP length bytes and form the window bound usable for this word.
  always_comb begin
    lane_off_l = '0;
    l_hi_here  = 1'b0;
    l_lo_here  = 1'b0;
    l_hi_val   = '0;
    l_lo_val   = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      lane_off_l = 17'(eth_count_base_i) + 17'(n);
      if (lane_data[n] && lane_off_l == b17 + 17'd44) begin
        l_hi_here = 1'b1;
        l_hi_val  = rxd_i[8*n +: 8];
      end
      if (lane_data[n] && lane_off_l == b17 + 17'd45) begin
        l_lo_here = 1'b1;
        l_lo_val  = rxd_i[8*n +: 8];
      end
    end
    // Length is usable if already captured, or completed by this very word.
    l_known = l_have_q || (l_lo_here && (l_hi_here || l_hi_have_q));
    l_eff   = l_have_q ? l_q : {(l_hi_here ? l_hi_val : l_hi_q), l_lo_val};
    win_end = b17 + 17'd40 + 17'(l_eff);
  end

  // Weight and add every accepted byte of the word; track the checksum field and the highest offset.
  always_comb begin
    lane_off_s   = '0;
    rel_s        = '0;
    lane_byte_s  = '0;
    lane_acc     = 1'b0;
    lane_word    = '0;
    word_sum_all = '0;
    word_sum_x   = '0;
    any_acc      = 1'b0;
    last_end     = '0;
    cs_hi_here   = 1'b0;
    cs_lo_here   = 1'b0;
    cs_hi_val    = '0;
    cs_lo_val    = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      lane_off_s  = 17'(eth_count_base_i) + 17'(n);
      rel_s       = lane_off_s - b17;
      lane_byte_s = rxd_i[8*n +: 8];
      // Before the length is known only bytes ahead of the length field may be taken.
      lane_acc    = lane_data[n] && (lane_off_s >= b17 + 17'd8) &&
                    (l_known ? (lane_off_s < win_end) : (lane_off_s < b17 + 17'd44));
      lane_word   = rel_s[0] ? {8'h00, lane_byte_s} : {lane_byte_s, 8'h00};
      if (lane_acc) begin
        word_sum_all = word_sum_all + 20'(lane_word);
        if (rel_s != 17'd46 && rel_s != 17'd47) word_sum_x = word_sum_x + 20'(lane_word);
        if (rel_s == 17'd46) begin
          cs_hi_here = 1'b1;
          cs_hi_val  = lane_byte_s;
        end
        if (rel_s == 17'd47) begin
          cs_lo_here = 1'b1;
          cs_lo_val  = lane_byte_s;
        end
        any_acc  = 1'b1;
        last_end = lane_off_s + 17'd1;
      end
    end
  end

  // Add length and next-header, then fold end-around carries down to 16 bits.
  always_comb begin
    t_all      = 20'(acc_all_q[15:0]) + 20'(acc_all_q[19:16]) + 20'(l_q) + 20'h00011;
    t_x        = 20'(acc_x_q[15:0])   + 20'(acc_x_q[19:16])   + 20'(l_q) + 20'h00011;
    f1_all     = 17'(t_all[15:0]) + 17'(t_all[19:16]);
    f1_x       = 17'(t_x[15:0])   + 17'(t_x[19:16]);
    f2_all     = f1_all[15:0] + 16'(f1_all[16]);
    f2_x       = f1_x[15:0]   + 16'(f1_x[16]);
    fold_trunc = !l_have_q || (l_q < 16'd8) || (end_q < b17 + 17'd40 + 17'(l_q));
    fold_zero  = cs_have_q && (cs_q == 16'h0000);
  end

  // Frame accumulation and result registers.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      acc_all_q   <= '0;
      acc_x_q     <= '0;
      l_q         <= '0;
      l_have_q    <= 1'b0;
      l_hi_q      <= '0;
      l_hi_have_q <= 1'b0;
      end_q       <= '0;
      cs_q        <= '0;
      cs_have_q   <= 1'b0;
      flag_q      <= 1'b0;
      res_ok_q    <= 1'b0;
      res_zero_q  <= 1'b0;
      res_trunc_q <= 1'b0;
      res_calc_q  <= '0;
    end else if (rx_clk_en_i) begin
      if (start_word && (state == IDLE || state == ACCUM)) begin
        acc_all_q   <= '0;
        acc_x_q     <= '0;
        l_q         <= '0;
        l_have_q    <= 1'b0;
        l_hi_q      <= '0;
        l_hi_have_q <= 1'b0;
        end_q       <= '0;
        cs_q        <= '0;
        cs_have_q   <= 1'b0;
        flag_q      <= 1'b0;
      end else if (state == ACCUM && !err_word) begin
        acc_all_q <= acc_add(acc_all_q, word_sum_all);
        acc_x_q   <= acc_add(acc_x_q, word_sum_x);
        if (l_hi_here) begin
          l_hi_q      <= l_hi_val;
          l_hi_have_q <= 1'b1;
        end
        if (l_known && !l_have_q) begin
          l_q      <= l_eff;
          l_have_q <= 1'b1;
        end
        if (cs_hi_here) cs_q[15:8] <= cs_hi_val;
        if (cs_lo_here) begin
          cs_q[7:0] <= cs_lo_val;
          cs_have_q <= 1'b1;
        end
        if (any_acc && last_end > end_q) end_q <= last_end;
        if (term_word) flag_q <= ipv6_flag_i;
      end
      if (state == FOLD) begin
        res_zero_q  <= fold_zero;
        res_trunc_q <= fold_trunc;
        res_ok_q    <= (f2_all == 16'hFFFF) && !fold_zero && !fold_trunc;
        res_calc_q  <= ~f2_x;
      end
    end
  end

  // State register.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) state <= IDLE;
    else if (rx_clk_en_i) state <= state_nx;
  end

  // Next-state logic and result strobe.
  always_comb begin
    state_nx    = state;
    chk_valid_o = 1'b0;
    case (state)
      IDLE:  if (start_word && ipv6_udp_chk_en_i && !err_word) state_nx = ACCUM;
      ACCUM: begin
        if (err_word)        state_nx = IDLE;
        else if (start_word) state_nx = ipv6_udp_chk_en_i ? ACCUM : IDLE;
        else if (term_word)  state_nx = FOLD;
      end
      FOLD:  state_nx = DONE;
      DONE: begin
        state_nx    = IDLE;
        chk_valid_o = flag_q;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign chk_ok_o      = res_ok_q;
  assign chk_zero_o    = res_zero_q;
  assign chk_trunc_o   = res_trunc_q;
  assign chksum_calc_o = res_calc_q;

endmodule

// File: tb/tb_ipv6_udp_chkverify.sv
// Directed bench for ipv6_udp_chkverify: PTP Sync over IPv6/UDP with
// hand-computed checksums (fe80::1 -> ff02::181, ports 319/319, L=52).
module tb_ipv6_udp_chkverify;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic        rx_clk_en;
  logic        chk_en;
  logic        ipv6_flag;
  logic [10:0] addr_base;
  logic [10:0] eth_base;
  logic [63:0] rxd;
  logic [7:0]  rxc;
  logic        chk_valid, chk_ok, chk_zero, chk_trunc;
  logic [15:0] chksum_calc;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  bit          en_toggle = 1'b0;
  logic [7:0]  frame [256];
  int          frame_len;

  always #5 rx_clk = ~rx_clk;

  ipv6_udp_chkverify dut (
    .rx_clk            (rx_clk),
    .rx_rst            (rx_rst),
    .rx_clk_en_i       (rx_clk_en),
    .ipv6_udp_chk_en_i (chk_en),
    .ipv6_flag_i       (ipv6_flag),
    .ipv6_addr_base_i  (addr_base),
    .eth_count_base_i  (eth_base),
    .rxd_i             (rxd),
    .rxc_i             (rxc),
    .chk_valid_o       (chk_valid),
    .chk_ok_o          (chk_ok),
    .chk_zero_o        (chk_zero),
    .chk_trunc_o       (chk_trunc),
    .chksum_calc_o     (chksum_calc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One enabled clock per word; optionally followed by one disabled clock.
  task automatic drive_word(input logic [63:0] d, input logic [7:0] c, input logic [10:0] base);
    rxd       = d;
    rxc       = c;
    eth_base  = base;
    rx_clk_en = 1'b1;
    @(posedge rx_clk); #1;
    if (en_toggle) begin
      rx_clk_en = 1'b0;
      @(posedge rx_clk); #1;
      rx_clk_en = 1'b1;
    end
  endtask

  task automatic idle_word();
    drive_word({8{8'h07}}, 8'hFF, 11'd0);
  endtask

  task automatic build_frame(input int b, input logic [15:0] csum, input bit flip, input int pad);
    for (int i = 0; i < 256; i++) frame[i] = 8'h00;
    for (int i = 0; i < b; i++) frame[i] = 8'(8'h20 + i);
    frame[b-2] = 8'h86; frame[b-1] = 8'hDD;
    frame[b+0] = 8'h60; frame[b+5] = 8'h34; frame[b+6] = 8'h11; frame[b+7] = 8'h40;
    frame[b+8]  = 8'hFE; frame[b+9]  = 8'h80; frame[b+23] = 8'h01;
    frame[b+24] = 8'hFF; frame[b+25] = 8'h02; frame[b+38] = 8'h01; frame[b+39] = 8'h81;
    frame[b+40] = 8'h01; frame[b+41] = 8'h3F; frame[b+42] = 8'h01; frame[b+43] = 8'h3F;
    frame[b+44] = 8'h00; frame[b+45] = 8'h34;
    frame[b+46] = csum[15:8]; frame[b+47] = csum[7:0];
    frame[b+49] = 8'h02; frame[b+51] = 8'h2C; frame[b+54] = 8'h02;
    frame[b+78] = 8'h12; frame[b+79] = 8'h34;
    if (flip) frame[b+60] = frame[b+60] ^ 8'hFF;
    for (int i = 0; i < pad; i++) frame[b+92+i] = 8'hA5;
    frame[b+92+pad] = 8'hDE; frame[b+93+pad] = 8'hAD;
    frame[b+94+pad] = 8'hBE; frame[b+95+pad] = 8'hEF;
    frame_len = b + 96 + pad;
  endtask

  // Send start word, then bytes [0,nbytes) and a terminate at nbytes.
  // err_w plants 0xFE on lane 3 of that word; rst_w pulses reset there and stops.
  task automatic send_frame(input int nbytes, input int err_w, input int rst_w);
    logic [63:0] d;
    logic [7:0]  c;
    drive_word(64'hD5555555_555555FB, 8'h01, 11'd0);
    for (int w = 0; 8*w <= nbytes; w++) begin
      d = '0;
      c = '0;
      for (int n = 0; n < 8; n++) begin
        if (8*w + n < nbytes) begin
          d[8*n +: 8] = frame[8*w + n];
        end else if (8*w + n == nbytes) begin
          d[8*n +: 8] = 8'hFD; c[n] = 1'b1;
        end else begin
          d[8*n +: 8] = 8'h07; c[n] = 1'b1;
        end
      end
      if (w == err_w) begin
        d[31:24] = 8'hFE; c[3] = 1'b1;
      end
      if (w == rst_w) begin
        rx_rst = 1'b1;
        drive_word(d, c, 11'(8*w));
        rx_rst = 1'b0;
        return;
      end
      drive_word(d, c, 11'(8*w));
    end
  endtask

  task automatic expect_result(input string tag, input bit exp_valid, input bit exp_ok,
                               input bit exp_zero, input bit exp_trunc, input logic [15:0] exp_calc);
    int          pulses = 0;
    int          lat    = 0;
    logic        ok_s = 1'b0, zero_s = 1'b0, trunc_s = 1'b0;
    logic [15:0] calc_s = '0;
    for (int k = 1; k <= 10; k++) begin
      idle_word();
      if (chk_valid) begin
        pulses++;
        if (pulses == 1) begin
          lat     = k + 1;
          ok_s    = chk_ok;
          zero_s  = chk_zero;
          trunc_s = chk_trunc;
          calc_s  = chksum_calc;
        end
      end
    end
    check({tag, "_strobes"}, 32'(pulses), exp_valid ? 32'd1 : 32'd0);
    if (exp_valid) begin
      check({tag, "_latency"}, 32'(lat), 32'd2);
      check({tag, "_ok"}, 32'(ok_s), 32'(exp_ok));
      check({tag, "_zero"}, 32'(zero_s), 32'(exp_zero));
      check({tag, "_trunc"}, 32'(trunc_s), 32'(exp_trunc));
      check({tag, "_calc"}, 32'(calc_s), 32'(exp_calc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_rst    = 1'b1;
    rx_clk_en = 1'b1;
    chk_en    = 1'b1;
    ipv6_flag = 1'b1;
    addr_base = 11'd14;
    eth_base  = 11'd0;
    rxd       = {8{8'h07}};
    rxc       = 8'hFF;
    repeat (3) @(posedge rx_clk);
    #1;
    check("rst_valid", 32'(chk_valid), 32'd0);
    check("rst_ok", 32'(chk_ok), 32'd0);
    check("rst_zero", 32'(chk_zero), 32'd0);
    check("rst_trunc", 32'(chk_trunc), 32'd0);
    check("rst_calc", 32'(chksum_calc), 32'h0);
    rx_rst = 1'b0;
    repeat (2) idle_word();

    // Good PTP Sync, checksum 0xE9A0.
    build_frame(14, 16'hE9A0, 1'b0, 0);
    send_frame(frame_len, -1, -1);
    expect_result("good", 1'b1, 1'b1, 1'b0, 1'b0, 16'hE9A0);

    // Payload byte B+60 flipped 00->FF: recomputed 0xEA9F.
    build_frame(14, 16'hE9A0, 1'b1, 0);
    send_frame(frame_len, -1, -1);
    expect_result("flip", 1'b1, 1'b0, 1'b0, 1'b0, 16'hEA9F);

    // Zero checksum field is illegal for IPv6.
    build_frame(14, 16'h0000, 1'b0, 0);
    send_frame(frame_len, -1, -1);
    expect_result("zero", 1'b1, 1'b0, 1'b1, 1'b0, 16'hE9A0);

    // Terminated at B+70: sequence id 0x1234 never arrives, recomputed 0xFBD4.
    build_frame(14, 16'hE9A0, 1'b0, 0);
    send_frame(14 + 70, -1, -1);
    expect_result("trunc", 1'b1, 1'b0, 1'b0, 1'b1, 16'hFBD4);

    // Error character mid-payload aborts; next frame is clean.
    build_frame(14, 16'hE9A0, 1'b0, 0);
    send_frame(frame_len, 8, -1);
    expect_result("err", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    send_frame(frame_len, -1, -1);
    expect_result("after_err", 1'b1, 1'b1, 1'b0, 1'b0, 16'hE9A0);

    // Reset mid-frame clears results and discards the frame.
    send_frame(frame_len, -1, 7);
    check("rst_mid_ok", 32'(chk_ok), 32'd0);
    expect_result("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    send_frame(frame_len, -1, -1);
    expect_result("after_rst", 1'b1, 1'b1, 1'b0, 1'b0, 16'hE9A0);

    // VLAN offset, 30 pad bytes of 0xA5, clock enable toggling.
    addr_base = 11'd18;
    en_toggle = 1'b1;
    build_frame(18, 16'hE9A0, 1'b0, 30);
    send_frame(frame_len, -1, -1);
    expect_result("vlan_pad", 1'b1, 1'b1, 1'b0, 1'b0, 16'hE9A0);
    en_toggle = 1'b0;

    // Not an IPv6/UDP frame: strobe suppressed.
    ipv6_flag = 1'b0;
    send_frame(frame_len, -1, -1);
    expect_result("noflag", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    ipv6_flag = 1'b1;

    // Verification disabled at start word.
    chk_en = 1'b0;
    send_frame(frame_len, -1, -1);
    expect_result("disabled", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ipv6_udp_chkverify.md
IPV6_UDP_CHKVERIFY -- requirements
Module: ipv6_udp_chkverify

Interface
REQ-001 SHALL have port rx_clk, input, 1 bit: receive clock; all logic is on its rising edge.
REQ-002 SHALL have port rx_rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port rx_clk_en_i, input, 1 bit: clock enable; while it is 0, no state or output changes.
REQ-004 SHALL have port ipv6_udp_chk_en_i, input, 1 bit: verification enable, sampled on the start word.
REQ-005 SHALL have port ipv6_flag_i, input, 1 bit: the current frame is IPv6/UDP; sampled on the terminate word.
REQ-006 SHALL have port ipv6_addr_base_i, input, 11 bits: frame byte offset of the IPv6 header; always even; stable from the start word to the end of frame.
REQ-007 SHALL have port eth_count_base_i, input, 11 bits: frame byte offset of lane 0 of the current word.
REQ-008 SHALL have ports rxd_i (input, 64 bits) and rxc_i (input, 8 bits): XGMII receive data and control, with lane n at bits [8n+7:8n].
REQ-009 SHALL have port chk_valid_o, output, 1 bit: one-cycle result strobe.
REQ-010 SHALL have port chk_ok_o, output, 1 bit: the checksum is correct; meaningful only with chk_valid_o.
REQ-011 SHALL have port chk_zero_o, output, 1 bit: the received UDP checksum field was 0x0000, which is illegal for IPv6.
REQ-012 SHALL have port chk_trunc_o, output, 1 bit: the frame ended before the UDP datagram ended.
REQ-013 SHALL have port chksum_calc_o, output, 16 bits: the folded sum, excluding the received checksum field, ones' complemented.

Function
REQ-014 SHALL define start of frame as lane 0 = 0xFB with rxc_i[0]=1, and end of frame as any lane n = 0xFD with rxc_i[n]=1 (the terminate word).
REQ-015 SHALL define error as any lane = 0xFE with its rxc bit set; an error aborts the frame: return to IDLE, no strobe.
REQ-016 SHALL use state machine IDLE -> ACCUM (on start, if ipv6_udp_chk_en_i=1) -> FOLD (on terminate word) -> DONE -> IDLE. A start seen in ACCUM restarts accumulation.
REQ-017 SHALL accept a data byte only when its rxc bit is 0, it precedes the terminate lane, and its offset o satisfies B+8 <= o < B+40+L, where B = ipv6_addr_base_i and L = UDP length.
REQ-018 SHALL capture L from offsets B+44 (MSB) and B+45 (LSB).
REQ-019 SHALL include bytes at offset B+44 or later only once L has been captured, either in an earlier cycle or from the same word, whichever gives the correct bound.
REQ-020 SHALL weight each accepted byte as the high byte when (o-B) is even and as the low byte when odd; this covers the pseudo-header addresses, the UDP header and the payload.
REQ-021 SHALL add all accepted bytes of a word in one cycle into a 20-bit accumulator, cleared on start.
REQ-022 SHALL, in FOLD, add L and 16'h0011 (next header) to the accumulator, then fold end-around carries to 16 bits (two additions).
REQ-023 SHALL capture the received checksum field from offsets B+46/B+47 and keep a second sum that excludes it.
REQ-024 SHALL raise chk_valid_o in DONE, i.e. 2 enabled cycles after the terminate word.
REQ-025 SHALL set chk_ok_o = (folded total == 16'hFFFF) & ~chk_zero_o & ~chk_trunc_o.
REQ-026 SHALL set chk_trunc_o = 1 when the highest accepted offset + 1 < B+40+L, or when L was never captured.
REQ-027 SHALL suppress chk_valid_o when ipv6_flag_i = 0 on the terminate word; the FSM still proceeds to IDLE.
REQ-028 SHALL ignore bytes beyond B+40+L (Ethernet pad, FCS).
REQ-029 SHALL treat L < 8 as truncated.

Reset
REQ-030 SHALL, on rx_rst=1 (taking precedence over rx_clk_en_i), enter IDLE, clear the accumulators and L, and drive chk_valid_o, chk_ok_o, chk_zero_o and chk_trunc_o to 0 and chksum_calc_o to 16'h0000.
REQ-031 SHALL, when reset is asserted mid-frame, discard that frame with no strobe; a frame starting after reset release is processed normally.

Verification
REQ-032 SHALL verify: B=14, PTP Sync with L=52 and a correct checksum -> chk_valid_o pulses 2 cycles after the terminate word, chk_ok_o=1, chksum_calc_o equals the transmitted field.
REQ-033 SHALL verify: same frame with payload byte B+60 flipped -> chk_ok_o=0, chk_trunc_o=0, chk_zero_o=0.
REQ-034 SHALL verify: checksum field 0x0000 -> chk_ok_o=0, chk_zero_o=1.
REQ-035 SHALL verify: L=52 with the frame terminated at offset B+70 -> chk_trunc_o=1, chk_ok_o=0.
REQ-036 SHALL verify: 0xFE on lane 3 mid-payload, or rx_rst pulsed mid-frame -> no chk_valid_o; the next good frame passes with chk_ok_o=1.
REQ-037 SHALL verify: B=18 (VLAN), 30 bytes of Ethernet pad after the datagram, rx_clk_en_i toggling 1/0 -> chk_ok_o=1 and pad bytes are ignored.
